// File: rtl/rx_pkg.sv
// Shared constants and types for the receive-side byte-load FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_pkg;

    localparam int RX_DATA_W    = 8;
    localparam int RX_DEPTH_DEF = 4;

    typedef logic [RX_DATA_W-1:0] rx_byte_t;

endpackage : rx_pkg

// File: rtl/rx_load_fifo_if.sv
// Byte-load / valid-ready bundle between a byte sender, the rx FIFO and its consumer.
// Latency: n/a (wires only).
// Backpressure: consumer holds q_ready low to stall; the sender has none (drops are flagged).
// Ports: load_en/d (write side), q/q_valid/q_ready (read side), clr_ovf, full/empty/overflow/count status.
interface rx_load_fifo_if
    import rx_pkg::*;
#(
    parameter int DATA_W = RX_DATA_W,
    parameter int DEPTH  = RX_DEPTH_DEF
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              load_en;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] q;
    logic              q_valid;
    logic              q_ready;
    logic              clr_ovf;
    logic              full;
    logic              empty;
    logic              overflow;
    logic [CNT_W-1:0]  count;

    // Environment side: byte sender plus downstream consumer.
    modport master (
        output load_en, d, q_ready, clr_ovf,
        input  q, q_valid, full, empty, overflow, count
    );

    // FIFO side.
    modport slave (
        input  load_en, d, q_ready, clr_ovf,
        output q, q_valid, full, empty, overflow, count
    );

endinterface : rx_load_fifo_if

// File: rtl/rx_fifo_mem.sv
// Flop-array storage for the rx FIFO: one synchronous write port, one async read port.
// Latency: write lands at the rising edge; read is combinational from raddr.
// Backpressure: none; the caller only asserts we when a push is accepted.
// Ports: clk, we/waddr/wdata (write), raddr -> rdata (read). Contents are not reset.
module rx_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : rx_fifo_mem

// File: rtl/rx_load_fifo.sv
// Receive endpoint of the byte-load interface: captures d on load_en into a FWFT FIFO.
// Latency: a byte loaded into an empty FIFO is on q with q_valid right after the capturing edge.
// Backpressure: q_ready stalls the head; a load while full with no pop is dropped and sets sticky overflow.
// Ports: clk, reset_n (async, active-low), bus (rx_load_fifo_if.slave).
module rx_load_fifo
    import rx_pkg::*;
#(
    parameter int DATA_W = RX_DATA_W,
    parameter int DEPTH  = RX_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    rx_load_fifo_if.slave     bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Pointer wrap relies on DEPTH being a power of two.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("rx_load_fifo: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic [DATA_W-1:0] head_dat;

    logic is_full;
    logic is_empty;
    logic pop;
    logic push;
    logic drop;

    assign is_full  = (cnt == CNT_W'(DEPTH));
    assign is_empty = (cnt == '0);
    assign pop      = !is_empty && bus.q_ready;
    // A pop at the same edge frees the slot, so a load while full still goes in.
    assign push     = bus.load_en && (!is_full || pop);
    assign drop     = bus.load_en && is_full && !pop;

    rx_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.d),
        .raddr (rd_ptr),
        .rdata (head_dat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            // A fresh drop outranks a clear at the same edge.
            if (drop) begin
                ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    // Storage is never reset, so the head must be masked while empty.
    assign bus.q        = is_empty ? '0 : head_dat;
    assign bus.q_valid  = !is_empty;
    assign bus.full     = is_full;
    assign bus.empty    = is_empty;
    assign bus.overflow = ovf;
    assign bus.count    = cnt;

endmodule : rx_load_fifo
